// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types for the PLL lock supervisor: sequencer states and the sizing
// rule for its single shared cycle counter.
package pll_sup_pkg;

   typedef enum logic [2:0] {
      HOLD,
      WAIT_LOCK,
      STABLE,
      RUN,
      FAIL
   } sup_state_t;

   localparam int RETRY_W = 4;

   // One counter serves every timed state, so it is sized for the longest interval.
   function automatic int cnt_width(input int hold_cyc, input int timeout_cyc, input int stable_cyc);
      int m;
      m = hold_cyc;
      if (timeout_cyc > m) m = timeout_cyc;
      if (stable_cyc > m) m = stable_cyc;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal; both flops
// clear to 0 on the asynchronous reset.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_reg;
   logic sync_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_reg <= 1'b0;
         sync_reg <= 1'b0;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer on the reference clock. Optional macro
// PLL_SUP_AUTO_RELOCK_EN: lock loss in RUN re-resets the PLL instead of only re-waiting.
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int RST_HOLD_CYC     = 16,
   parameter int LOCK_TIMEOUT_CYC = 9000,
   parameter int LOCK_STABLE_CYC  = 256,
   parameter int MAX_RETRY        = 3
) (
   input  logic               clkin,
   input  logic               reset,
   input  logic               pll_lock,
   input  logic               restart,
   output logic               pll_reset,
   output logic               rst_out,
   output logic               locked,
   output logic               fail,
   output logic [RETRY_W-1:0] retry_cnt
);

   localparam int CNT_W = cnt_width(RST_HOLD_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC);
   localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD_CYC - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
   localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);
   localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);
   localparam logic [RETRY_W-1:0] RETRY_SAT    = '1;

   logic lock_s;

   sync_2ff u_lock_sync (
      .clk (clkin),
      .rst (reset),
      .d   (pll_lock),
      .q   (lock_s)
   );

   sup_state_t         state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [RETRY_W-1:0] retry_reg, retry_next, retry_inc;
   logic               pll_reset_reg, rst_out_reg, locked_reg, fail_reg;

   assign retry_inc = (retry_reg == RETRY_SAT) ? retry_reg : retry_reg + RETRY_W'(1);

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg + CNT_ONE;
      retry_next = retry_reg;
      if (restart) begin
         state_next = HOLD;
         cnt_next   = '0;
         retry_next = '0;
      end else begin
         case (state_reg)
            HOLD: begin
               if (cnt_reg == HOLD_LAST) begin
                  state_next = WAIT_LOCK;
                  cnt_next   = '0;
               end
            end
            WAIT_LOCK: begin
               // Lock wins over a timeout landing on the same cycle.
               if (lock_s) begin
                  state_next = STABLE;
                  cnt_next   = '0;
               end else if (cnt_reg == TIMEOUT_LAST) begin
                  retry_next = retry_inc;
                  cnt_next   = '0;
                  state_next = (retry_inc == RETRY_LIMIT) ? FAIL : HOLD;
               end
            end
            STABLE: begin
               if (!lock_s) begin
                  state_next = WAIT_LOCK;
                  cnt_next   = '0;
               end else if (cnt_reg == STABLE_LAST) begin
                  state_next = RUN;
                  cnt_next   = '0;
               end
            end
            RUN: begin
               cnt_next = '0;
               if (!lock_s) begin
`ifdef PLL_SUP_AUTO_RELOCK_EN
                  state_next = HOLD;
`else
                  state_next = WAIT_LOCK;
`endif
               end
            end
            FAIL: begin
               cnt_next = '0;
            end
            default: begin
               state_next = HOLD;
               cnt_next   = '0;
            end
         endcase
      end
   end

   // Outputs decode the next state so they move on the same edge as the state.
   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         state_reg     <= HOLD;
         cnt_reg       <= '0;
         retry_reg     <= '0;
         pll_reset_reg <= 1'b1;
         rst_out_reg   <= 1'b1;
         locked_reg    <= 1'b0;
         fail_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         retry_reg     <= retry_next;
         pll_reset_reg <= (state_next == HOLD) || (state_next == FAIL);
         rst_out_reg   <= (state_next != RUN);
         locked_reg    <= (state_next == RUN);
         fail_reg      <= (state_next == FAIL);
      end
   end

   assign pll_reset = pll_reset_reg;
   assign rst_out   = rst_out_reg;
   assign locked    = locked_reg;
   assign fail      = fail_reg;
   assign retry_cnt = retry_reg;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: a phase/deadline model checked every
// cycle, plus hand-computed timing expectations for each scenario.
`timescale 1ns/1ps
module tb_pll_lock_supervisor;

   localparam int H  = 4;
   localparam int T  = 20;
   localparam int S  = 8;
   localparam int MR = 3;

   localparam int SEL_PLL_RESET = 0;
   localparam int SEL_RST_OUT   = 1;
   localparam int SEL_LOCKED    = 2;
   localparam int SEL_RETRY     = 3;

   localparam int P_HOLD   = 0;
   localparam int P_WAIT   = 1;
   localparam int P_STABLE = 2;
   localparam int P_RUN    = 3;
   localparam int P_FAIL   = 4;

   logic       clkin    = 1'b0;
   logic       reset    = 1'b1;
   logic       pll_lock = 1'b0;
   logic       restart  = 1'b0;
   logic       pll_reset, rst_out, locked, fail;
   logic [3:0] retry_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clkin = ~clkin;

   pll_lock_supervisor #(
      .RST_HOLD_CYC     (H),
      .LOCK_TIMEOUT_CYC (T),
      .LOCK_STABLE_CYC  (S),
      .MAX_RETRY        (MR)
   ) dut (
      .clkin     (clkin),
      .reset     (reset),
      .pll_lock  (pll_lock),
      .restart   (restart),
      .pll_reset (pll_reset),
      .rst_out   (rst_out),
      .locked    (locked),
      .fail      (fail),
      .retry_cnt (retry_cnt)
   );

   // Model: current phase plus cycles left before that phase's deadline.
   int         m_phase = P_HOLD;
   int         m_left  = H;
   int         m_retry = 0;
   logic [1:0] m_sync  = 2'b00;

   function automatic int bumped(input int r);
      return (r < 15) ? r + 1 : 15;
   endfunction

   always @(posedge clkin or posedge reset) begin
      if (reset) begin
         m_phase <= P_HOLD;
         m_left  <= H;
         m_retry <= 0;
         m_sync  <= 2'b00;
      end else begin
         m_sync <= {m_sync[0], pll_lock};
         if (restart) begin
            m_phase <= P_HOLD;
            m_left  <= H;
            m_retry <= 0;
         end else begin
            case (m_phase)
               P_HOLD: begin
                  if (m_left == 1) begin m_phase <= P_WAIT; m_left <= T; end
                  else m_left <= m_left - 1;
               end
               P_WAIT: begin
                  if (m_sync[1]) begin
                     m_phase <= P_STABLE;
                     m_left  <= S;
                  end else if (m_left == 1) begin
                     m_retry <= bumped(m_retry);
                     m_phase <= (bumped(m_retry) == MR) ? P_FAIL : P_HOLD;
                     m_left  <= H;
                  end else begin
                     m_left <= m_left - 1;
                  end
               end
               P_STABLE: begin
                  if (!m_sync[1]) begin m_phase <= P_WAIT; m_left <= T; end
                  else if (m_left == 1) m_phase <= P_RUN;
                  else m_left <= m_left - 1;
               end
               P_RUN: begin
                  if (!m_sync[1]) begin
`ifdef PLL_SUP_AUTO_RELOCK_EN
                     m_phase <= P_HOLD;
                     m_left  <= H;
`else
                     m_phase <= P_WAIT;
                     m_left  <= T;
`endif
                  end
               end
               default: m_phase <= P_FAIL;
            endcase
         end
      end
   end

   always @(negedge clkin) begin : cmp
      logic [7:0] exp_v;
      logic [7:0] act_v;
      exp_v = {(m_phase == P_HOLD) || (m_phase == P_FAIL), m_phase != P_RUN,
               m_phase == P_RUN, m_phase == P_FAIL, 4'(m_retry)};
      act_v = {pll_reset, rst_out, locked, fail, retry_cnt};
      total++;
      if (act_v !== exp_v) begin
         bad++;
         $display("FAIL cycle_model t=%0t {pll_reset,rst_out,locked,fail,retry} got %b want %b",
                  $time, act_v, exp_v);
      end
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end else begin
         $display("ok   %s = %0d", name, act);
      end
   endtask

   function automatic int sig(input int sel);
      case (sel)
         SEL_PLL_RESET: return int'(pll_reset);
         SEL_RST_OUT:   return int'(rst_out);
         SEL_LOCKED:    return int'(locked);
         default:       return int'(retry_cnt);
      endcase
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clkin);
         #1;
      end
   endtask

   // Returns the number of rising edges until the selected output equals val, -1 if never.
   task automatic edges_until(input int sel, input int val, input int limit, output int n);
      n = -1;
      for (int i = 1; i <= limit; i++) begin
         @(posedge clkin);
         #1;
         if (sig(sel) == val) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic pulse_restart();
      restart = 1'b1;
      tick(1);
      restart = 1'b0;
   endtask

   initial begin
      int n;
      tick(3);
      check("reset_pll_reset", pll_reset, 1);
      check("reset_rst_out", rst_out, 1);
      check("reset_locked", locked, 0);
      check("reset_fail", fail, 0);
      check("reset_retry", retry_cnt, 0);

      // Nominal bring-up
      reset = 1'b0;
      edges_until(SEL_PLL_RESET, 0, 20, n);
      check("nominal_hold_cycles", n, H);
      tick(10 - H);
      pll_lock = 1'b1;
      edges_until(SEL_RST_OUT, 0, 40, n);
      check("nominal_lock_to_release", n, 2 + S + 1);
      check("nominal_locked", locked, 1);

      // Lock glitch during STABLE
      pll_lock = 1'b0;
      tick(3);
      pulse_restart();
      tick(8);
      pll_lock = 1'b1;
      tick(6);
      pll_lock = 1'b0;
      tick(2);
      pll_lock = 1'b1;
      edges_until(SEL_RST_OUT, 0, 40, n);
      check("glitch_return_to_release", n, 2 + S + 1);

      // Timeouts into FAIL
      pll_lock = 1'b0;
      tick(3);
      pulse_restart();
      for (int k = 1; k <= MR; k++) begin
         edges_until(SEL_RETRY, k, 40, n);
         check($sformatf("timeout%0d_cycles", k), n, H + T);
         check($sformatf("timeout%0d_pll_reset", k), pll_reset, 1);
         check($sformatf("timeout%0d_fail", k), fail, (k == MR) ? 1 : 0);
      end
      tick(30);
      check("fail_sticky", fail, 1);
      check("fail_pll_reset", pll_reset, 1);
      check("fail_retry", retry_cnt, MR);

      // Restart out of FAIL
      pulse_restart();
      check("restart_retry", retry_cnt, 0);
      check("restart_fail", fail, 0);
      check("restart_pll_reset", pll_reset, 1);
      pll_lock = 1'b1;
      edges_until(SEL_LOCKED, 1, 40, n);
      check("restart_to_run", n, H + 1 + S);

      // Lock loss in RUN
      pll_lock = 1'b0;
      edges_until(SEL_RST_OUT, 1, 10, n);
      check("loss_to_rst_out", n, 3);
`ifdef PLL_SUP_AUTO_RELOCK_EN
      check("relock_pll_reset", pll_reset, 1);
      edges_until(SEL_PLL_RESET, 0, 10, n);
      check("relock_hold_cycles", n, H);
      check("relock_retry", retry_cnt, 0);
`else
      tick(6);
      check("noreloc_pll_reset", pll_reset, 0);
      check("noreloc_rst_out", rst_out, 1);
`endif

      // Asynchronous reset while in STABLE
      pll_lock = 1'b1;
      pulse_restart();
      tick(8);
      check("stable_pll_reset", pll_reset, 0);
      check("stable_rst_out", rst_out, 1);
      #2;
      reset = 1'b1;
      #1;
      check("async_pll_reset", pll_reset, 1);
      check("async_rst_out", rst_out, 1);
      check("async_locked", locked, 0);
      check("async_fail", fail, 0);
      check("async_retry", retry_cnt, 0);
      tick(2);
      reset = 1'b0;
      tick(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
